// File: rtl/dbg_pkg.sv
// dbg_pkg: shared definitions for the debug-domain memory bridge.
//   - axi_tx_state_e : sender FSM states
//   - SIZE_*         : access size encodings (byte, halfword, word)
//   - *_DEF          : default values for the axi_tx parameters
package dbg_pkg;

    typedef enum logic [2:0] {
        StHold,
        StIdle,
        StWait,
        StResp,
        StDrain
    } axi_tx_state_e;

    localparam logic [2:0] SIZE_B = 3'd0;
    localparam logic [2:0] SIZE_H = 3'd1;
    localparam logic [2:0] SIZE_W = 3'd2;

    localparam int unsigned IGNORE_CYC_DEF = 15;
    localparam int unsigned TIMEOUT_W_DEF  = 16;

endpackage

// File: rtl/dbg_sync.sv
// dbg_sync: generic two-flop synchronizer, synchronous active-high reset to 0.
// Ports:
//   i_clk  destination clock
//   i_rst  synchronous active-high reset
//   i_d    asynchronous input
//   o_q    synchronized output (two destination-clock cycles of latency)
module dbg_sync #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/axi_tx.sv
// axi_tx: debug-domain sender of the toggle-handshake memory bridge.
// Accepts one memory access at a time on the req_* port, publishes a stable
// payload plus a tx_tog flip to the receiver, waits for rx_tog to match and
// returns the read data / error on the rsp_* port.
// Ports:
//   i_tx_clk, i_tx_rst              clock, synchronous active-high reset
//   i_req_* / o_req_ready           request handshake and payload
//   o_rsp_* / i_rsp_ready           response handshake and payload
//   o_busy                          high whenever the FSM is not idle
//   o_tx_tog, o_tx_mem_*            flopped outputs to the receiver
//   i_rx_tog, i_rx_mem_*            receiver acknowledge (asynchronous)
// Build option: define AXI_TX_TIMEOUT_EN to add the WAIT timeout counter.
module axi_tx
    import dbg_pkg::*;
#(
    parameter int unsigned IGNORE_CYC = IGNORE_CYC_DEF,
    parameter int unsigned TIMEOUT_W  = TIMEOUT_W_DEF
) (
    input  logic        i_tx_clk,
    input  logic        i_tx_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [31:0] i_req_addr,
    input  logic        i_req_write,
    input  logic [31:0] i_req_wdata,
    input  logic [2:0]  i_req_size,
    input  logic [6:0]  i_req_prot,
    input  logic        i_req_secen,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_slverr,
    output logic        o_rsp_timeout,
    output logic        o_busy,
    output logic        o_tx_tog,
    output logic [31:0] o_tx_mem_addr,
    output logic        o_tx_mem_write,
    output logic [31:0] o_tx_mem_wdata,
    output logic [2:0]  o_tx_mem_size,
    output logic [6:0]  o_tx_mem_prot,
    output logic        o_tx_mem_secen,
    input  logic        i_rx_tog,
    input  logic [31:0] i_rx_mem_rdata,
    input  logic        i_rx_mem_slverr
);

    localparam int unsigned HoldW = $clog2(IGNORE_CYC + 2);

    axi_tx_state_e r_state;
    axi_tx_state_e w_state_nxt;
    logic [HoldW-1:0] r_hold_cnt;
    logic        r_req_ready;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_slverr;
    logic        r_tx_tog;
    logic [31:0] r_tx_addr;
    logic        r_tx_write;
    logic [31:0] r_tx_wdata;
    logic [2:0]  r_tx_size;
    logic [6:0]  r_tx_prot;
    logic        r_tx_secen;

    logic        w_rx_tog_s;
    logic        w_match;
    logic        w_load_tx;
    logic        w_load_rsp;
    logic [31:0] w_rsp_rdata;
    logic        w_rsp_slverr;

    dbg_sync #(
        .WIDTH (1)
    ) u_rx_tog_sync (
        .i_clk (i_tx_clk),
        .i_rst (i_tx_rst),
        .i_d   (i_rx_tog),
        .o_q   (w_rx_tog_s)
    );

    // Level compare: any number of missed toggles still resolves to a match.
    assign w_match = (w_rx_tog_s == r_tx_tog);

`ifdef AXI_TX_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] r_to_cnt;
    logic                 r_rsp_timeout;
    logic                 w_rsp_to;

    always_ff @(posedge i_tx_clk) begin
        if (i_tx_rst) begin
            r_to_cnt <= '0;
        end else if (w_load_tx) begin
            r_to_cnt <= '0;
        end else if (r_state == StWait) begin
            r_to_cnt <= r_to_cnt + TIMEOUT_W'(1);
        end
    end

    always_ff @(posedge i_tx_clk) begin
        if (i_tx_rst) begin
            r_rsp_timeout <= 1'b0;
        end else if (w_load_rsp) begin
            r_rsp_timeout <= w_rsp_to;
        end
    end

    assign o_rsp_timeout = r_rsp_timeout;
`else
    logic [TIMEOUT_W-1:0] w_unused_to;
    assign w_unused_to   = '0;
    assign o_rsp_timeout = 1'b0;
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_load_tx    = 1'b0;
        w_load_rsp   = 1'b0;
        w_rsp_rdata  = '0;
        w_rsp_slverr = 1'b0;
`ifdef AXI_TX_TIMEOUT_EN
        w_rsp_to     = 1'b0;
`endif
        unique case (r_state)
            StHold: begin
                // A receiver left toggled across our reset is flushed in DRAIN.
                if (r_hold_cnt <= HoldW'(1)) begin
                    w_state_nxt = w_match ? StIdle : StDrain;
                end
            end
            StIdle: begin
                if (i_req_valid && r_req_ready) begin
                    if (i_req_size <= SIZE_W) begin
                        w_load_tx   = 1'b1;
                        w_state_nxt = StWait;
                    end else begin
                        w_load_rsp   = 1'b1;
                        w_rsp_slverr = 1'b1;
                        w_state_nxt  = StResp;
                    end
                end
            end
            StWait: begin
                // Two synchronizer stages guarantee rx_mem_* has settled here.
                if (w_match) begin
                    w_load_rsp   = 1'b1;
                    w_rsp_rdata  = i_rx_mem_rdata;
                    w_rsp_slverr = i_rx_mem_slverr;
                    w_state_nxt  = StResp;
                end
`ifdef AXI_TX_TIMEOUT_EN
                else if (&r_to_cnt) begin
                    w_load_rsp   = 1'b1;
                    w_rsp_slverr = 1'b1;
                    w_rsp_to     = 1'b1;
                    w_state_nxt  = StResp;
                end
`endif
            end
            StResp: begin
                if (i_rsp_ready) begin
`ifdef AXI_TX_TIMEOUT_EN
                    // The late acknowledge of a timed-out access is absorbed in DRAIN.
                    w_state_nxt = r_rsp_timeout ? StDrain : StIdle;
`else
                    w_state_nxt = StIdle;
`endif
                end
            end
            StDrain: begin
                if (w_match) begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StHold;
        endcase
    end

    always_ff @(posedge i_tx_clk) begin
        if (i_tx_rst) begin
            r_state      <= StHold;
            r_hold_cnt   <= HoldW'(IGNORE_CYC);
            r_req_ready  <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_rdata  <= '0;
            r_rsp_slverr <= 1'b0;
            r_tx_tog     <= 1'b0;
            r_tx_addr    <= '0;
            r_tx_write   <= 1'b0;
            r_tx_wdata   <= '0;
            r_tx_size    <= '0;
            r_tx_prot    <= '0;
            r_tx_secen   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_req_ready <= (w_state_nxt == StIdle);
            r_rsp_valid <= (w_state_nxt == StResp);
            if ((r_state == StHold) && (r_hold_cnt != '0)) begin
                r_hold_cnt <= r_hold_cnt - HoldW'(1);
            end
            if (w_load_tx) begin
                r_tx_tog   <= ~r_tx_tog;
                r_tx_addr  <= i_req_addr;
                r_tx_write <= i_req_write;
                r_tx_wdata <= i_req_wdata;
                r_tx_size  <= i_req_size;
                r_tx_prot  <= i_req_prot;
                r_tx_secen <= i_req_secen;
            end
            if (w_load_rsp) begin
                r_rsp_rdata  <= w_rsp_rdata;
                r_rsp_slverr <= w_rsp_slverr;
            end
        end
    end

    assign o_req_ready    = r_req_ready;
    assign o_rsp_valid    = r_rsp_valid;
    assign o_rsp_rdata    = r_rsp_rdata;
    assign o_rsp_slverr   = r_rsp_slverr;
    assign o_busy         = (r_state != StIdle);
    assign o_tx_tog       = r_tx_tog;
    assign o_tx_mem_addr  = r_tx_addr;
    assign o_tx_mem_write = r_tx_write;
    assign o_tx_mem_wdata = r_tx_wdata;
    assign o_tx_mem_size  = r_tx_size;
    assign o_tx_mem_prot  = r_tx_prot;
    assign o_tx_mem_secen = r_tx_secen;

endmodule

// File: tb/tb_axi_tx.sv
// tb_axi_tx: directed bench for axi_tx with a transaction-level model.
// The model tracks the expected toggle parity, the last accepted payload and a
// queue of expected responses; a negedge process compares the DUT every cycle.
module tb_axi_tx;

`ifdef AXI_TX_TIMEOUT_EN
    localparam int unsigned TW = 4;
`else
    localparam int unsigned TW = 16;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic        req_write = 1'b0;
    logic [31:0] req_wdata = '0;
    logic [2:0]  req_size = '0;
    logic [6:0]  req_prot = '0;
    logic        req_secen = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_slverr;
    logic        rsp_timeout;
    logic        busy;
    logic        tx_tog;
    logic [31:0] tx_mem_addr;
    logic        tx_mem_write;
    logic [31:0] tx_mem_wdata;
    logic [2:0]  tx_mem_size;
    logic [6:0]  tx_mem_prot;
    logic        tx_mem_secen;
    logic        rx_tog = 1'b0;
    logic [31:0] rx_mem_rdata = '0;
    logic        rx_mem_slverr = 1'b0;

    always #5 clk = ~clk;

    axi_tx #(
        .IGNORE_CYC (15),
        .TIMEOUT_W  (TW)
    ) dut (
        .i_tx_clk        (clk),
        .i_tx_rst        (rst),
        .i_req_valid     (req_valid),
        .o_req_ready     (req_ready),
        .i_req_addr      (req_addr),
        .i_req_write     (req_write),
        .i_req_wdata     (req_wdata),
        .i_req_size      (req_size),
        .i_req_prot      (req_prot),
        .i_req_secen     (req_secen),
        .o_rsp_valid     (rsp_valid),
        .i_rsp_ready     (rsp_ready),
        .o_rsp_rdata     (rsp_rdata),
        .o_rsp_slverr    (rsp_slverr),
        .o_rsp_timeout   (rsp_timeout),
        .o_busy          (busy),
        .o_tx_tog        (tx_tog),
        .o_tx_mem_addr   (tx_mem_addr),
        .o_tx_mem_write  (tx_mem_write),
        .o_tx_mem_wdata  (tx_mem_wdata),
        .o_tx_mem_size   (tx_mem_size),
        .o_tx_mem_prot   (tx_mem_prot),
        .o_tx_mem_secen  (tx_mem_secen),
        .i_rx_tog        (rx_tog),
        .i_rx_mem_rdata  (rx_mem_rdata),
        .i_rx_mem_slverr (rx_mem_slverr)
    );

    typedef struct packed {
        logic [31:0] rdata;
        logic        slverr;
        logic        tmo;
    } rsp_t;

    rsp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic        started = 1'b0;
    logic        m_tog   = 1'b0;
    logic [31:0] m_addr  = '0;
    logic        m_write = 1'b0;
    logic [31:0] m_wdata = '0;
    logic [2:0]  m_size  = '0;
    logic [6:0]  m_prot  = '0;
    logic        m_secen = 1'b0;
    // What the receiver will answer for the next good request.
    logic [31:0] rx_cfg_data = '0;
    logic        rx_cfg_err  = 1'b0;
    logic        exp_tmo     = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Check current outputs, then advance the model for the coming edge.
    always @(negedge clk) begin
        rsp_t f;
        if (started) begin
            chk("tx_tog", tx_tog, m_tog);
            chk("tx_mem_addr", tx_mem_addr, m_addr);
            chk("tx_mem_write", tx_mem_write, m_write);
            chk("tx_mem_wdata", tx_mem_wdata, m_wdata);
            chk("tx_mem_size", tx_mem_size, m_size);
            chk("tx_mem_prot", tx_mem_prot, m_prot);
            chk("tx_mem_secen", tx_mem_secen, m_secen);
            chk("busy_vs_ready", busy, !req_ready);
            chk("rsp_unexpected", rsp_valid && (exp_q.size() == 0), 1'b0);
            if (rsp_valid && exp_q.size() > 0) begin
                f = exp_q[0];
                chk("rsp_rdata", rsp_rdata, f.rdata);
                chk("rsp_slverr", rsp_slverr, f.slverr);
                chk("rsp_timeout", rsp_timeout, f.tmo);
            end
        end
        if (rst) begin
            started = 1'b1;
            m_tog   = 1'b0;
            m_addr  = '0;
            m_write = 1'b0;
            m_wdata = '0;
            m_size  = '0;
            m_prot  = '0;
            m_secen = 1'b0;
            exp_q.delete();
        end else begin
            if (rsp_valid && rsp_ready && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
            end
            if (req_valid && req_ready) begin
                if (req_size <= 3'd2) begin
                    m_tog   = ~m_tog;
                    m_addr  = req_addr;
                    m_write = req_write;
                    m_wdata = req_wdata;
                    m_size  = req_size;
                    m_prot  = req_prot;
                    m_secen = req_secen;
                    if (exp_tmo) exp_q.push_back('{rdata: 32'h0, slverr: 1'b1, tmo: 1'b1});
                    else exp_q.push_back('{rdata: rx_cfg_data, slverr: rx_cfg_err, tmo: 1'b0});
                end else begin
                    exp_q.push_back('{rdata: 32'h0, slverr: 1'b1, tmo: 1'b0});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request until accepted; returns cycles spent waiting.
    task automatic send_req(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                            input logic [2:0] size, input logic [6:0] prot, input logic secen,
                            output int waited);
        logic acc;
        acc       = 1'b0;
        waited    = 0;
        req_valid = 1'b1;
        req_addr  = addr;
        req_write = wr;
        req_wdata = wdata;
        req_size  = size;
        req_prot  = prot;
        req_secen = secen;
        while (!acc && waited < 200) begin
            @(negedge clk);
            if (req_ready) acc = 1'b1;
            else waited++;
            tick();
        end
        req_valid = 1'b0;
        chk("req_accepted", acc, 1'b1);
    endtask

    // Receiver: after lat cycles return data and acknowledge.
    task automatic rx_respond(input int lat, input logic [31:0] data, input logic err);
        for (int i = 0; i < lat; i++) tick();
        rx_mem_rdata  = data;
        rx_mem_slverr = err;
        rx_tog        = tx_tog;
    endtask

    task automatic wait_rsp(input string name, output int n);
        n = 0;
        while (!rsp_valid && n < 100) begin
            tick();
            n++;
        end
        chk(name, rsp_valid, 1'b1);
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!req_ready && n < 100) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        repeat (3) tick();
        chk("rst_req_ready", req_ready, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_busy", busy, 1'b1);
        chk("rst_tx_tog", tx_tog, 1'b0);
        chk("rst_tx_addr", tx_mem_addr, 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_slverr", rsp_slverr, 1'b0);
        chk("rst_rsp_timeout", rsp_timeout, 1'b0);
        rst = 1'b0;
        wait_ready(n);
        chk("hold_cycles", n, 15);

        // Word read.
        rx_cfg_data = 32'hDEADBEEF;
        rx_cfg_err  = 1'b0;
        send_req(32'h1000, 1'b0, 32'h0, 3'd2, 7'h02, 1'b1, n);
        chk("t1_tog_flip", tx_tog, 1'b1);
        chk("t1_addr", tx_mem_addr, 32'h1000);
        chk("t1_ready_low", req_ready, 1'b0);
        rx_respond(2, 32'hDEADBEEF, 1'b0);
        wait_rsp("t1_rsp_seen", n);
        chk("t1_rsp_lat", n, 3);
        chk("t1_rdata", rsp_rdata, 32'hDEADBEEF);
        chk("t1_slverr", rsp_slverr, 1'b0);
        handshake();
        chk("t1_ready_after", req_ready, 1'b1);

        // Byte write with slave error.
        rx_cfg_data = 32'h0;
        rx_cfg_err  = 1'b1;
        send_req(32'h1003, 1'b1, 32'hA5, 3'd0, 7'h00, 1'b0, n);
        chk("t2_tog", tx_tog, 1'b0);
        chk("t2_wdata", tx_mem_wdata, 32'hA5);
        rx_respond(5, 32'h0, 1'b1);
        wait_rsp("t2_rsp_seen", n);
        chk("t2_slverr", rsp_slverr, 1'b1);
        handshake();

        // Unsupported size: immediate error, no toggle.
        send_req(32'h2000, 1'b0, 32'h0, 3'd3, 7'h01, 1'b0, n);
        chk("t3_rsp_valid", rsp_valid, 1'b1);
        chk("t3_no_flip", tx_tog, 1'b0);
        chk("t3_rdata", rsp_rdata, 32'h0);
        chk("t3_slverr", rsp_slverr, 1'b1);
        chk("t3_addr_kept", tx_mem_addr, 32'h1003);
        handshake();

        // Back-pressure.
        rx_cfg_data = 32'hCAFE0001;
        rx_cfg_err  = 1'b0;
        send_req(32'h3000, 1'b0, 32'h0, 3'd1, 7'h04, 1'b0, n);
        rx_respond(1, 32'hCAFE0001, 1'b0);
        wait_rsp("t4_rsp_seen", n);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t4_hold_valid", rsp_valid, 1'b1);
            chk("t4_hold_rdata", rsp_rdata, 32'hCAFE0001);
            chk("t4_ready_low", req_ready, 1'b0);
        end
        handshake();
        rx_cfg_data = 32'h0BADF00D;
        send_req(32'h3004, 1'b0, 32'h0, 3'd2, 7'h04, 1'b0, n);
        chk("t4_next_accept", n, 0);
        rx_respond(0, 32'h0BADF00D, 1'b0);
        wait_rsp("t4b_rsp_seen", n);
        handshake();

        // Receiver left toggled across reset.
        rx_tog = 1'b1;
        rst    = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        for (int i = 0; i < 25; i++) begin
            tick();
            chk("t5_ready_low", req_ready, 1'b0);
        end
        rx_tog = 1'b0;
        wait_ready(n);
        chk("t5_drain_exit", n, 3);

`ifdef AXI_TX_TIMEOUT_EN
        // No acknowledge: timeout, then absorb the late toggle in DRAIN.
        exp_tmo = 1'b1;
        send_req(32'h4000, 1'b0, 32'h0, 3'd2, 7'h00, 1'b0, n);
        exp_tmo = 1'b0;
        wait_rsp("t6_rsp_seen", n);
        chk("t6_to_lat", n, 16);
        chk("t6_timeout", rsp_timeout, 1'b1);
        chk("t6_slverr", rsp_slverr, 1'b1);
        handshake();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t6_drain_ready", req_ready, 1'b0);
        end
        rx_respond(0, 32'h55555555, 1'b0);
        wait_ready(n);
        chk("t6_drain_exit", n, 3);
        rx_cfg_data = 32'h600D0001;
        rx_cfg_err  = 1'b0;
        send_req(32'h4004, 1'b0, 32'h0, 3'd2, 7'h00, 1'b0, n);
        rx_respond(1, 32'h600D0001, 1'b0);
        wait_rsp("t6b_rsp_seen", n);
        chk("t6b_rdata", rsp_rdata, 32'h600D0001);
        chk("t6b_timeout", rsp_timeout, 1'b0);
        handshake();
`endif

        // Final read with prot/secen variety.
        rx_cfg_data = 32'h13579BDF;
        rx_cfg_err  = 1'b0;
        send_req(32'h5000, 1'b0, 32'h0, 3'd2, 7'h7F, 1'b1, n);
        rx_respond(3, 32'h13579BDF, 1'b0);
        wait_rsp("t7_rsp_seen", n);
        chk("t7_rdata", rsp_rdata, 32'h13579BDF);
        handshake();
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
